keypad_scanner: RTL and testbench

//  4x4 matrix keypad front end. Drives one column low at a time and samples the
//  row lines. It encodes the first pressed key into a 4-bit hex code.
//  It feeds key_code/key_pressed to the downstream debouncer (sig_in/key_pressed).

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/keypad_scanner.sv | 111 +++++++++++
 tb/tb_keypad_scanner.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key map and row-priority helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [0:0] {SCAN = 1'b0, HOLD = 1'b1} scan_state_t;

  typedef logic [3:0] key_code_t;

  // Indexed [row][col]; row 3 carries the E/0/F/D layout of a telephone-style pad.
  localparam key_code_t KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [1:0] first_row(input logic [3:0] hit);
    logic [1:0] idx;
    if (hit[0])      idx = 2'd0;
    else if (hit[1]) idx = 2'd1;
    else if (hit[2]) idx = 2'd2;
    else             idx = 2'd3;
    return idx;
  endfunction

  function automatic logic exactly_one(input logic [3:0] hit);
    return (hit != 4'b0000) && ((hit & (hit - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; flops reset to all ones (idle pull-up level).
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with hold-on-press; optional GHOST_REJECT_EN rejects multi-row hits.
// dbg_state exposes the SCAN/HOLD state (0 = SCAN, 1 = HOLD).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 48000,
  localparam int CNT_W   = $clog2(SCAN_DIV)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_pressed,
  output logic       new_key,
  output logic       dbg_state
);

  logic [3:0]       rs;
  logic [3:0]       hit;
  logic             sample;

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       held_row_q, held_row_d;
  key_code_t        key_code_q, key_code_d;
  logic             key_pressed_q, key_pressed_d;
  logic             new_key_q, new_key_d;
  logic             accept_press;
  logic             still_held;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (rs)
  );

  assign hit    = ~rs;
  assign sample = (cnt_q == CNT_W'(SCAN_DIV - 1));

`ifdef GHOST_REJECT_EN
  // Two or more rows low in one column may be a ghost; only a lone row counts.
  assign accept_press = exactly_one(hit);
  assign still_held   = (hit == (4'b0001 << held_row_q));
`else
  assign accept_press = (hit != 4'b0000);
  assign still_held   = hit[held_row_q];
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = sample ? '0 : cnt_q + CNT_W'(1);
    col_idx_d     = col_idx_q;
    held_row_d    = held_row_q;
    key_code_d    = key_code_q;
    key_pressed_d = key_pressed_q;
    new_key_d     = 1'b0;
    if (sample) begin
      case (state_q)
        SCAN: begin
          if (accept_press) begin
            state_d       = HOLD;
            held_row_d    = first_row(hit);
            key_code_d    = KEYMAP[first_row(hit)][col_idx_q];
            key_pressed_d = 1'b1;
            new_key_d     = 1'b1;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        HOLD: begin
          if (!still_held) begin
            state_d       = SCAN;
            key_pressed_d = 1'b0;
            col_idx_d     = col_idx_q + 2'd1;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SCAN;
      cnt_q         <= '0;
      col_idx_q     <= 2'd0;
      held_row_q    <= 2'd0;
      key_code_q    <= 4'h0;
      key_pressed_q <= 1'b0;
      new_key_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      col_idx_q     <= col_idx_d;
      held_row_q    <= held_row_d;
      key_code_q    <= key_code_d;
      key_pressed_q <= key_pressed_d;
      new_key_q     <= new_key_d;
    end
  end

  assign col         = ~(4'b0001 << col_idx_q);
  assign key_code    = key_code_q;
  assign key_pressed = key_pressed_q;
  assign new_key     = new_key_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner (SCAN_DIV=8): keypad model, directed presses, new_key scoreboard.
module tb_keypad_scanner;

  localparam int DIV       = 8;
  localparam int PRESS_MAX = 4 * DIV + 3;
  localparam int REL_MAX   = DIV + 3;

  logic       clk;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_pressed;
  logic       new_key;
  logic       dbg_state;

  logic [15:0] keys;   // keys[r*4+c] = key (r,c) held down

  int tests;
  int fails;

  // expected {col, key_code} for each new_key pulse
  logic [7:0] exp_q[$];

  keypad_scanner #(.SCAN_DIV(DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_pressed (key_pressed),
    .new_key     (new_key),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- keypad model ----------------
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rotl(input logic [3:0] v, input int n);
    logic [3:0] t;
    t = v;
    for (int i = 0; i < n; i++) t = {t[2:0], t[3]};
    return t;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && new_key) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_new_key: got col=%b code=%h expected no pulse at %0t",
                 col, key_code, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if ({col, key_code} !== e) begin
          fails++;
          $display("FAIL new_key_payload: got col=%b code=%h expected col=%b code=%h at %0t",
                   col, key_code, e[7:4], e[3:0], $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic press(input int r, input int c);
    keys[r*4+c] = 1'b1;
  endtask

  task automatic release_all();
    keys = 16'h0000;
  endtask

  task automatic wait_pressed(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while (key_pressed !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {7'd0, key_pressed}, {7'd0, lvl});
  endtask

  task automatic press_and_check(input int r, input int c, input logic [3:0] code);
    logic [3:0] exp_col;
    exp_col = 4'b1111;
    exp_col[c] = 1'b0;
    exp_q.push_back({exp_col, code});
    press(r, c);
    wait_pressed(1'b1, PRESS_MAX, "press_latency");
    @(negedge clk);
    check("held_col", {4'h0, col}, {4'h0, exp_col});
    check("held_code", {4'h0, key_code}, {4'h0, code});
    check("new_key_single", {7'd0, new_key}, 8'd0);
  endtask

  task automatic release_and_check(input logic [3:0] exp_col_after);
    release_all();
    wait_pressed(1'b0, REL_MAX, "release_latency");
    check("resume_col", {4'h0, col}, {4'h0, exp_col_after});
    check("resume_state", {7'd0, dbg_state}, 8'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests = 0;
    fails = 0;
    keys  = 16'h0000;
    reset = 1'b1;

    // 1) reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_col", {4'h0, col}, 8'h0E);
    check("reset_code", {4'h0, key_code}, 8'h00);
    check("reset_pressed", {7'd0, key_pressed}, 8'd0);
    check("reset_new_key", {7'd0, new_key}, 8'd0);
    check("reset_state", {7'd0, dbg_state}, 8'd0);
    reset = 1'b0;

    // 2) idle scanning: column advances on every 8th edge
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("idle_col", {4'h0, col}, {4'h0, rotl(4'b1110, ((i + 1) / DIV) % 4)});
    end

    // 3) key (1,2) -> 6, frozen at col2, resumes at col3
    press_and_check(1, 2, 4'h6);
    repeat (20) @(negedge clk);
    check("hold_stable_col", {4'h0, col}, 8'h0B);
    check("hold_stable_pressed", {7'd0, key_pressed}, 8'd1);
    release_and_check(4'b0111);

    // 4) (0,0) and (2,0) together
`ifdef GHOST_REJECT_EN
    press(0, 0);
    press(2, 0);
    begin
      logic saw_press;
      logic saw_move;
      logic [3:0] first_col;
      saw_press = 1'b0;
      saw_move  = 1'b0;
      first_col = col;
      for (int i = 0; i < 48; i++) begin
        @(negedge clk);
        if (key_pressed) saw_press = 1'b1;
        if (col !== first_col) saw_move = 1'b1;
      end
      check("ghost_no_press", {7'd0, saw_press}, 8'd0);
      check("ghost_scan_moves", {7'd0, saw_move}, 8'd1);
    end
    release_all();
    repeat (4) @(negedge clk);
`else
    begin
      exp_q.push_back({4'b1110, 4'h1});
      press(0, 0);
      press(2, 0);
      wait_pressed(1'b1, PRESS_MAX, "multi_press_latency");
      @(negedge clk);
      check("multi_code", {4'h0, key_code}, 8'h01);
      release_and_check(4'b1101);
    end
`endif

    // 5) hold on (3,1) -> 0, then press (0,3): ignored
    press_and_check(3, 1, 4'h0);
    press(0, 3);
    repeat (40) @(negedge clk);
    check("other_col_code", {4'h0, key_code}, 8'h00);
    check("other_col_col", {4'h0, col}, 8'h0D);
    check("other_col_pressed", {7'd0, key_pressed}, 8'd1);
    release_and_check(4'b1011);

    // a few more map entries
    press_and_check(0, 3, 4'hA);
    release_and_check(4'b1110);
    press_and_check(3, 0, 4'hE);
    release_and_check(4'b1101);
    press_and_check(2, 2, 4'h9);
    release_and_check(4'b0111);
    press_and_check(3, 3, 4'hD);
    release_and_check(4'b1110);

    // 6) reset mid-HOLD on (1,3)
    press_and_check(1, 3, 4'hB);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_col", {4'h0, col}, 8'h0E);
    check("midreset_pressed", {7'd0, key_pressed}, 8'd0);
    check("midreset_code", {4'h0, key_code}, 8'h00);
    check("midreset_new_key", {7'd0, new_key}, 8'd0);
    check("midreset_state", {7'd0, dbg_state}, 8'd0);
    release_all();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // hard bound in case a wait loop is broken
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
